mm_vmx_cfg_seq: RTL and testbench
=================================

# mm_vmx_cfg_seq

AXI4-Lite master sequencer that configures and launches the mm_vmx accelerator without processor involvement. On a start pulse it:
- writes a block of configuration words to consecutive mm_vmx registers;
- writes the GO register;
- polls the status register until the done bit is set, a bus error occurs, or a poll timeout expires;
- reports the outcome with a single-cycle done pulse and an error code.

It sits between the PL-side job scheduler and the mm_vmx S00_AXI slave port.

## Interface
Parameters:
- C_M_AXI_ADDR_WIDTH, 4: AXI address width.
- C_M_AXI_DATA_WIDTH, 32: AXI data width (only 32 supported).
- NUM_CFG, 2: configuration words written, at addresses 0x0, 0x4, …, (NUM_CFG-1)*4.
- GO_ADDR, 4'h8: register receiving GO_VALUE after configuration.
- GO_VALUE, 32'h1: value written to GO_ADDR.
- STAT_ADDR, 4'hC: status register polled.
- STAT_BIT, 0: status bit meaning "done".
- POLL_MAX, 1024: maximum status reads before timeout (≥1).

Ports:
- ACLK in 1: clock; all logic rising-edge.
- ARESET in 1: synchronous, active-high reset.
- start in 1: single-cycle request; ignored while busy=1.
- cfg_data in NUM_CFG*32: config words; word k = bits [32k+31:32k]; sampled on accepted start.
- busy out 1: sequence in progress.
- done out 1: one-cycle completion pulse.
- err_code out 2: 0 OK, 1 write SLVERR/DECERR, 2 read SLVERR/DECERR, 3 timeout; held until next accepted start.
- poll_cnt out 16: status reads issued in the last/current sequence.
- m_axi_awaddr out C_M_AXI_ADDR_WIDTH; m_axi_awprot out 3 (tied 3'b000); m_axi_awvalid out 1; m_axi_awready in 1.
- m_axi_wdata out 32; m_axi_wstrb out 4 (tied 4'hF); m_axi_wvalid out 1; m_axi_wready in 1.
- m_axi_bresp in 2; m_axi_bvalid in 1; m_axi_bready out 1.
- m_axi_araddr out C_M_AXI_ADDR_WIDTH; m_axi_arprot out 3 (tied 3'b000); m_axi_arvalid out 1; m_axi_arready in 1.
- m_axi_rdata in 32; m_axi_rresp in 2; m_axi_rvalid in 1; m_axi_rready out 1.

## Operation
States:
- **IDLE**
  - start=1 → latch cfg_data; clear err_code and poll_cnt; idx=0; go to WADDR.
- **WADDR**
  - Drive awvalid and wvalid together.
  - Address/data: idx<NUM_CFG → (idx*4, cfg word idx); idx=NUM_CFG → (GO_ADDR, GO_VALUE).
  - Each valid drops independently after its own handshake.
  - When both handshakes are done → WRESP.
- **WRESP**
  - bready=1; wait for bvalid.
  - bresp≠0 → err_code=1, go to FIN.
  - idx<NUM_CFG → idx+1, back to WADDR.
  - Otherwise → RADDR.
- **RADDR**
  - arvalid=1 with araddr=STAT_ADDR.
  - On arready → poll_cnt+1, go to RDATA.
- **RDATA**
  - rready=1; wait for rvalid.
  - rresp≠0 → err_code=2, go to FIN.
  - rdata[STAT_BIT]=1 → FIN.
  - Else poll_cnt==POLL_MAX → err_code=3, go to FIN.
  - Else → RADDR.
- **FIN**
  - done=1 for one cycle, then IDLE.

Rules:
- busy=1 in every state except IDLE.
- Exactly one outstanding transaction at a time; never a read and a write concurrently.
- AW/W address and data are stable while their valid is high (AXI rule); valid is never dropped before its handshake.
- Sequence length for a successful run: NUM_CFG+1 writes, then ≥1 reads.
- poll_cnt saturates at 16'hFFFF.

## Timing
- Reset values: all valids 0, bready 0, rready 0, busy 0, done 0, err_code 0, poll_cnt 0, state IDLE.
- ARESET mid-sequence: next edge forces reset values, even with a handshake pending. The slave is reset by the same ARESET.
- Start cycle:
  - start sampled at edge N → busy=1, awvalid=1, wvalid=1 from N+1.
  - start during busy has no effect; start in the FIN cycle is ignored.
- Per-transaction latency with zero-wait slave: write 2 cycles (WADDR, WRESP); read 2 cycles (RADDR, RDATA).
- Ready before valid: awready/wready/arready already high when valid rises → handshake completes in the first valid cycle.
- Done latency:
  - done asserts the cycle after the terminating bvalid/rvalid handshake.
  - busy falls in the same cycle done falls.
- Handshake ordering: awready and wready may arrive in either order or in the same cycle. The write response is not awaited until both have completed.

## Test plan
1. **Zero-wait slave, NUM_CFG=2**, cfg {0x11,0x22}, status bit0 set on 3rd read.
   - Writes (0x0,0x11), (0x4,0x22), (0x8,0x1); 3 reads of 0xC.
   - done pulse, err_code=0, poll_cnt=3.
   - start-to-done = 1 + 3×2 + 3×2 + 1 cycles.
2. **Random back-pressure** on awready/wready/bvalid/arready/rvalid, including W accepted before AW.
   - Identical transaction list and data.
   - No valid drops or payload change before its handshake.
3. **SLVERR write**: bresp=2'b10 on the GO write.
   - No reads issued; err_code=1; done pulse.
4. **Timeout**: POLL_MAX=4, status always 0.
   - Exactly 4 reads; err_code=3; poll_cnt=4.
5. **Start while busy, then reset mid-sequence**:
   - Second start during poll → ignored (no second write sequence).
   - ARESET during RDATA → next cycle all valids/readies 0, busy 0, err_code 0.
   - A fresh start afterwards completes normally.
6. **Read error**: rresp=2'b11 on the 1st poll.
   - err_code=2; poll_cnt=1; done pulse.

Source files
------------

// File: rtl/mm_vmx_cfg_seq.sv
// mm_vmx_cfg_seq
// AXI4-Lite master sequencer that configures and launches the mm_vmx
// accelerator without processor involvement. On an accepted start it:
//   1. writes NUM_CFG configuration words to 0x0, 0x4, ...;
//   2. writes GO_VALUE to GO_ADDR;
//   3. polls STAT_ADDR until bit STAT_BIT is set, a bus error occurs, or
//      POLL_MAX reads have been issued;
//   4. pulses done for one cycle and reports err_code.
//
// Ports
//   ACLK, ARESET     : clock (rising edge), synchronous active-high reset
//   start            : one-cycle request, ignored while busy
//   cfg_data         : config words, word k = bits [32k+31:32k], sampled on start
//   busy             : high in every state except idle
//   done             : one-cycle completion pulse
//   err_code         : 0 ok, 1 write error, 2 read error, 3 poll timeout
//   poll_cnt         : status reads issued in the last/current sequence
//   m_axi_*          : AXI4-Lite master (AW, W, B, AR, R channels)
module mm_vmx_cfg_seq #(
  parameter int unsigned                   C_M_AXI_ADDR_WIDTH = 4,
  parameter int unsigned                   C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned                   NUM_CFG            = 2,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] GO_ADDR            = 4'h8,
  parameter logic [31:0]                   GO_VALUE           = 32'h1,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] STAT_ADDR          = 4'hC,
  parameter int unsigned                   STAT_BIT           = 0,
  parameter int unsigned                   POLL_MAX           = 1024
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  input  logic                              start,
  input  logic [NUM_CFG*C_M_AXI_DATA_WIDTH-1:0] cfg_data,
  output logic                              busy,
  output logic                              done,
  output logic [1:0]                        err_code,
  output logic [15:0]                       poll_cnt,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic [2:0]                        m_axi_awprot,
  output logic                              m_axi_awvalid,
  input  logic                              m_axi_awready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                              m_axi_wvalid,
  input  logic                              m_axi_wready,
  input  logic [1:0]                        m_axi_bresp,
  input  logic                              m_axi_bvalid,
  output logic                              m_axi_bready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_araddr,
  output logic [2:0]                        m_axi_arprot,
  output logic                              m_axi_arvalid,
  input  logic                              m_axi_arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_rdata,
  input  logic [1:0]                        m_axi_rresp,
  input  logic                              m_axi_rvalid,
  output logic                              m_axi_rready
);

  localparam int unsigned DW    = C_M_AXI_DATA_WIDTH;
  localparam int unsigned AW    = C_M_AXI_ADDR_WIDTH;
  localparam int unsigned IDX_W = (NUM_CFG < 1) ? 1 : $clog2(NUM_CFG + 1);
  // idx == GO_IDX selects the GO write instead of a config word.
  localparam logic [IDX_W-1:0] GO_IDX = IDX_W'(NUM_CFG);

  localparam logic [1:0] ERR_OK   = 2'd0;
  localparam logic [1:0] ERR_WR   = 2'd1;
  localparam logic [1:0] ERR_RD   = 2'd2;
  localparam logic [1:0] ERR_TOUT = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WADDR,
    S_WRESP,
    S_RADDR,
    S_RDATA,
    S_FIN
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              aw_ok_q, aw_ok_d;
  logic              w_ok_q, w_ok_d;
  logic [1:0]        err_q, err_d;
  logic [15:0]       poll_q, poll_d;
  logic [DW-1:0]     cfg_q [NUM_CFG];
  logic              load_cfg;

  logic              aw_fire, w_fire;
  logic              unused_rdata;

  // Only the status bit of the read data is consumed.
  assign unused_rdata = ^m_axi_rdata;

  // Tied-off AXI attributes.
  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;
  assign m_axi_wstrb  = '1;
  assign m_axi_araddr = STAT_ADDR;

  // Channel controls decode directly from state; AW and W each drop
  // independently once their own handshake has been recorded.
  assign m_axi_awvalid = (state_q == S_WADDR) && !aw_ok_q;
  assign m_axi_wvalid  = (state_q == S_WADDR) && !w_ok_q;
  assign m_axi_bready  = (state_q == S_WRESP);
  assign m_axi_arvalid = (state_q == S_RADDR);
  assign m_axi_rready  = (state_q == S_RDATA);

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_FIN);
  assign err_code = err_q;
  assign poll_cnt = poll_q;

  assign aw_fire = m_axi_awvalid && m_axi_awready;
  assign w_fire  = m_axi_wvalid && m_axi_wready;

  // Write payload: idx only changes outside WADDR, so address and data
  // stay stable for as long as either valid is held.
  always_comb begin
    m_axi_awaddr = GO_ADDR;
    m_axi_wdata  = DW'(GO_VALUE);
    for (int unsigned k = 0; k < NUM_CFG; k++) begin
      if (idx_q == IDX_W'(k)) begin
        m_axi_awaddr = AW'(k * 4);
        m_axi_wdata  = cfg_q[k];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    aw_ok_d  = aw_ok_q;
    w_ok_d   = w_ok_q;
    err_d    = err_q;
    poll_d   = poll_q;
    load_cfg = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          load_cfg = 1'b1;
          err_d    = ERR_OK;
          poll_d   = '0;
          idx_d    = '0;
          aw_ok_d  = 1'b0;
          w_ok_d   = 1'b0;
          state_d  = S_WADDR;
        end
      end

      S_WADDR: begin
        if (aw_fire) aw_ok_d = 1'b1;
        if (w_fire)  w_ok_d  = 1'b1;
        if (aw_ok_d && w_ok_d) begin
          aw_ok_d = 1'b0;
          w_ok_d  = 1'b0;
          state_d = S_WRESP;
        end
      end

      S_WRESP: begin
        if (m_axi_bvalid) begin
          if (m_axi_bresp != 2'b00) begin
            err_d   = ERR_WR;
            state_d = S_FIN;
          end else if (idx_q != GO_IDX) begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_WADDR;
          end else begin
            state_d = S_RADDR;
          end
        end
      end

      S_RADDR: begin
        if (m_axi_arready) begin
          if (poll_q != '1) poll_d = poll_q + 16'd1;
          state_d = S_RDATA;
        end
      end

      S_RDATA: begin
        if (m_axi_rvalid) begin
          if (m_axi_rresp != 2'b00) begin
            err_d   = ERR_RD;
            state_d = S_FIN;
          end else if (m_axi_rdata[STAT_BIT]) begin
            state_d = S_FIN;
          end else if ({16'd0, poll_q} >= 32'(POLL_MAX)) begin
            err_d   = ERR_TOUT;
            state_d = S_FIN;
          end else begin
            state_d = S_RADDR;
          end
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      aw_ok_q <= 1'b0;
      w_ok_q  <= 1'b0;
      err_q   <= ERR_OK;
      poll_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      aw_ok_q <= aw_ok_d;
      w_ok_q  <= w_ok_d;
      err_q   <= err_d;
      poll_q  <= poll_d;
    end
  end

  // Config snapshot needs no reset: it is only read after a start loads it.
  always_ff @(posedge ACLK) begin
    if (load_cfg) begin
      for (int unsigned k = 0; k < NUM_CFG; k++) begin
        cfg_q[k] <= cfg_data[k*DW +: DW];
      end
    end
  end

endmodule

// File: tb/tb_mm_vmx_cfg_seq.sv
// Self-checking bench for mm_vmx_cfg_seq (NUM_CFG=2, POLL_MAX=4) with a
// behavioural AXI4-Lite slave that logs every write and read it accepts.
module tb_mm_vmx_cfg_seq;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        start;
  logic [63:0] cfg_data;
  logic        busy, done;
  logic [1:0]  err_code;
  logic [15:0] poll_cnt;
  logic [3:0]  m_axi_awaddr, m_axi_araddr;
  logic [2:0]  m_axi_awprot, m_axi_arprot;
  logic        m_axi_awvalid, m_axi_awready;
  logic [31:0] m_axi_wdata, m_axi_rdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wvalid, m_axi_wready;
  logic [1:0]  m_axi_bresp, m_axi_rresp;
  logic        m_axi_bvalid, m_axi_bready;
  logic        m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rready;

  int tests = 0;
  int fails = 0;

  mm_vmx_cfg_seq #(.POLL_MAX(4)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .start(start), .cfg_data(cfg_data),
    .busy(busy), .done(done), .err_code(err_code), .poll_cnt(poll_cnt),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  always #5 ACLK = ~ACLK;

  // Slave configuration (written by the test tasks only).
  int bp_mode    = 0;    // 0 zero-wait, 1 random stalls, 2 W accepted before AW
  int done_read  = 3;    // status bit0 set from this (1-based) read onwards
  int wr_err_idx = -1;   // 0-based write answered with SLVERR
  int rd_err_idx = -1;   // 1-based read answered with rresp=2'b11

  // Slave state and logs (written by the slave process only).
  int          wr_n, rd_n, w_first;
  logic [3:0]  wa_log [8];
  logic [31:0] wd_log [8];
  logic [3:0]  ra_log [16];
  bit          aw_have, w_have, b_pend, r_pend;
  logic [3:0]  aw_a;
  logic [31:0] w_d, r_data_nx;
  logic [1:0]  b_resp_nx, r_resp_nx;

  always @(posedge ACLK) begin
    if (ARESET) begin
      m_axi_awready <= 1'b0; m_axi_wready <= 1'b0; m_axi_arready <= 1'b0;
      m_axi_bvalid  <= 1'b0; m_axi_bresp  <= 2'b00;
      m_axi_rvalid  <= 1'b0; m_axi_rresp  <= 2'b00; m_axi_rdata <= '0;
      aw_have = 0; w_have = 0; b_pend = 0; r_pend = 0;
      wr_n = 0; rd_n = 0; w_first = 0;
    end else begin
      if (m_axi_awvalid && m_axi_awready) begin aw_have = 1; aw_a = m_axi_awaddr; end
      if (m_axi_wvalid && m_axi_wready) begin
        if (!aw_have) w_first++;
        w_have = 1; w_d = m_axi_wdata;
      end
      if (m_axi_bvalid && m_axi_bready) m_axi_bvalid <= 1'b0;
      if (aw_have && w_have) begin
        if (wr_n < 8) begin wa_log[wr_n] = aw_a; wd_log[wr_n] = w_d; end
        b_resp_nx = (wr_n == wr_err_idx) ? 2'b10 : 2'b00;
        wr_n++; aw_have = 0; w_have = 0; b_pend = 1;
      end
      if (b_pend && (bp_mode != 1 || $urandom_range(0, 2) == 0)) begin
        m_axi_bvalid <= 1'b1; m_axi_bresp <= b_resp_nx; b_pend = 0;
      end

      if (m_axi_arvalid && m_axi_arready) begin
        if (rd_n < 16) ra_log[rd_n] = m_axi_araddr;
        rd_n++;
        r_resp_nx = (rd_n == rd_err_idx) ? 2'b11 : 2'b00;
        r_data_nx = (rd_n >= done_read) ? 32'h0000_0001 : 32'hFFFF_FFFE;
        r_pend = 1;
      end
      if (m_axi_rvalid && m_axi_rready) m_axi_rvalid <= 1'b0;
      if (r_pend && (bp_mode != 1 || $urandom_range(0, 2) == 0)) begin
        m_axi_rvalid <= 1'b1; m_axi_rdata <= r_data_nx; m_axi_rresp <= r_resp_nx; r_pend = 0;
      end

      case (bp_mode)
        1: begin
          m_axi_awready <= 1'($urandom_range(0, 1));
          m_axi_wready  <= 1'($urandom_range(0, 1));
          m_axi_arready <= 1'($urandom_range(0, 1));
        end
        2: begin
          m_axi_wready  <= 1'b1;
          m_axi_awready <= w_have;
          m_axi_arready <= 1'b1;
        end
        default: begin
          m_axi_awready <= 1'b1; m_axi_wready <= 1'b1; m_axi_arready <= 1'b1;
        end
      endcase
    end
  end

  // Protocol monitor: pending valids must hold with a stable payload, and
  // reads and writes must never overlap.
  int          viol, done_cnt;
  bit          pa, pw, par;
  logic [3:0]  pa_addr;
  logic [31:0] pw_data;

  always @(posedge ACLK) begin
    if (ARESET) begin
      pa = 0; pw = 0; par = 0; viol = 0; done_cnt = 0;
    end else begin
      if (pa && (!m_axi_awvalid || m_axi_awaddr !== pa_addr)) viol++;
      if (pw && (!m_axi_wvalid || m_axi_wdata !== pw_data)) viol++;
      if (par && !m_axi_arvalid) viol++;
      if ((m_axi_awvalid || m_axi_wvalid || m_axi_bready) && (m_axi_arvalid || m_axi_rready)) viol++;
      if (done) done_cnt++;
      pa = m_axi_awvalid && !m_axi_awready; pa_addr = m_axi_awaddr;
      pw = m_axi_wvalid && !m_axi_wready;   pw_data = m_axi_wdata;
      par = m_axi_arvalid && !m_axi_arready;
    end
  end

  logic [3:0]  exp_a [3];
  logic [31:0] exp_d [3];

  initial begin
    exp_a[0] = 4'h0; exp_a[1] = 4'h4; exp_a[2] = 4'h8;
    exp_d[0] = 32'h11; exp_d[1] = 32'h22; exp_d[2] = 32'h1;
  end

  task automatic do_reset();
    @(negedge ACLK);
    ARESET = 1'b1; start = 1'b0;
    @(negedge ACLK);
    @(negedge ACLK);
    ARESET = 1'b0;
  endtask

  // Cycle count is inclusive: the start cycle is 1, the done cycle is the last.
  task automatic run_seq(input int limit, output int cyc, output bit seen);
    @(negedge ACLK);
    start = 1'b1; cyc = 1;
    @(negedge ACLK);
    start = 1'b0; cyc = 2;
    while (!done && cyc < limit) begin
      @(negedge ACLK);
      cyc++;
    end
    seen = done;
  endtask

  task automatic test_reset();
    bp_mode = 0; do_reset();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %0b want 0", done); end
    tests++; if (err_code !== 2'd0) begin fails++; $display("FAIL reset_err: got %0d want 0", err_code); end
    tests++; if (poll_cnt !== 16'd0) begin fails++; $display("FAIL reset_poll: got %0d want 0", poll_cnt); end
    tests++;
    if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready} !== 5'b0) begin
      fails++; $display("FAIL reset_handshake: got %05b want 00000",
                        {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready});
    end
    tests++;
    if ({m_axi_awprot, m_axi_arprot, m_axi_wstrb} !== 10'b000_000_1111) begin
      fails++; $display("FAIL tieoffs: got %010b want 0000001111", {m_axi_awprot, m_axi_arprot, m_axi_wstrb});
    end
  endtask

  task automatic test_zero_wait();
    int cyc; bit seen;
    bp_mode = 0; done_read = 3; wr_err_idx = -1; rd_err_idx = -1;
    cfg_data = {32'h22, 32'h11};
    do_reset();
    run_seq(200, cyc, seen);
    tests++; if (!seen) begin fails++; $display("FAIL zw_done: got 0 want 1"); end
    tests++; if (cyc != 1 + 3*2 + 3*2 + 1) begin fails++; $display("FAIL zw_latency: got %0d want 14", cyc); end
    tests++; if (err_code !== 2'd0) begin fails++; $display("FAIL zw_err: got %0d want 0", err_code); end
    tests++; if (poll_cnt !== 16'd3) begin fails++; $display("FAIL zw_poll: got %0d want 3", poll_cnt); end
    tests++; if (wr_n != 3) begin fails++; $display("FAIL zw_nwrites: got %0d want 3", wr_n); end
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (wa_log[i] !== exp_a[i] || wd_log[i] !== exp_d[i]) begin
        fails++; $display("FAIL zw_write%0d: got (%0h,%0h) want (%0h,%0h)", i, wa_log[i], wd_log[i], exp_a[i], exp_d[i]);
      end
    end
    tests++; if (rd_n != 3) begin fails++; $display("FAIL zw_nreads: got %0d want 3", rd_n); end
    for (int i = 0; i < 3; i++) begin
      tests++; if (ra_log[i] !== 4'hC) begin fails++; $display("FAIL zw_raddr%0d: got %0h want c", i, ra_log[i]); end
    end
    @(negedge ACLK);
    tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL zw_after: busy=%0b done=%0b want 0 0", busy, done); end
    tests++; if (done_cnt != 1) begin fails++; $display("FAIL zw_pulse: got %0d done cycles want 1", done_cnt); end
    tests++; if (viol != 0) begin fails++; $display("FAIL zw_protocol: got %0d violations want 0", viol); end
  endtask

  task automatic test_backpressure(input int mode);
    int cyc; bit seen;
    bp_mode = mode; done_read = 3; wr_err_idx = -1; rd_err_idx = -1;
    cfg_data = {32'h22, 32'h11};
    do_reset();
    run_seq(3000, cyc, seen);
    tests++; if (!seen) begin fails++; $display("FAIL bp%0d_done: got 0 want 1", mode); end
    tests++; if (err_code !== 2'd0 || poll_cnt !== 16'd3) begin
      fails++; $display("FAIL bp%0d_status: got err=%0d poll=%0d want 0 3", mode, err_code, poll_cnt); end
    tests++; if (wr_n != 3 || rd_n != 3) begin fails++; $display("FAIL bp%0d_counts: got w=%0d r=%0d want 3 3", mode, wr_n, rd_n); end
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (wa_log[i] !== exp_a[i] || wd_log[i] !== exp_d[i]) begin
        fails++; $display("FAIL bp%0d_write%0d: got (%0h,%0h) want (%0h,%0h)", mode, i, wa_log[i], wd_log[i], exp_a[i], exp_d[i]);
      end
    end
    tests++; if (viol != 0) begin fails++; $display("FAIL bp%0d_protocol: got %0d violations want 0", mode, viol); end
    if (mode == 2) begin
      tests++; if (w_first != 3) begin fails++; $display("FAIL bp2_wfirst: got %0d want 3", w_first); end
    end
  endtask

  task automatic test_back_to_back();
    int cyc; bit seen;
    bp_mode = 0; done_read = 1; wr_err_idx = -1; rd_err_idx = -1;
    cfg_data = {32'h22, 32'h11};
    do_reset();
    run_seq(200, cyc, seen);
    // Now in the FIN cycle: a start here must be ignored.
    start = 1'b1;
    @(negedge ACLK);
    start = 1'b0;
    @(negedge ACLK);
    tests++; if (busy !== 1'b0 || wr_n != 3) begin
      fails++; $display("FAIL fin_start: got busy=%0b writes=%0d want 0 3", busy, wr_n); end
    cfg_data = {32'h44, 32'h33};
    run_seq(200, cyc, seen);
    tests++; if (!seen || cyc != 1 + 3*2 + 1*2 + 1) begin
      fails++; $display("FAIL b2b_done: got seen=%0b cyc=%0d want 1 10", seen, cyc); end
    tests++; if (wr_n != 6 || wd_log[3] !== 32'h33 || wd_log[4] !== 32'h44 || wa_log[4] !== 4'h4) begin
      fails++; $display("FAIL b2b_writes: got n=%0d d3=%0h d4=%0h a4=%0h want 6 33 44 4", wr_n, wd_log[3], wd_log[4], wa_log[4]); end
  endtask

  task automatic test_write_err();
    int cyc; bit seen;
    bp_mode = 0; done_read = 1; wr_err_idx = 2; rd_err_idx = -1;
    cfg_data = {32'h22, 32'h11};
    do_reset();
    run_seq(200, cyc, seen);
    tests++; if (!seen || err_code !== 2'd1) begin fails++; $display("FAIL wr_err: got seen=%0b err=%0d want 1 1", seen, err_code); end
    tests++; if (wr_n != 3 || rd_n != 0 || poll_cnt !== 16'd0) begin
      fails++; $display("FAIL wr_err_counts: got w=%0d r=%0d poll=%0d want 3 0 0", wr_n, rd_n, poll_cnt); end
    wr_err_idx = -1;
  endtask

  task automatic test_timeout();
    int cyc; bit seen;
    bp_mode = 0; done_read = 1000; wr_err_idx = -1; rd_err_idx = -1;
    do_reset();
    run_seq(200, cyc, seen);
    tests++; if (!seen || err_code !== 2'd3) begin fails++; $display("FAIL tout_err: got seen=%0b err=%0d want 1 3", seen, err_code); end
    tests++; if (poll_cnt !== 16'd4 || rd_n != 4) begin
      fails++; $display("FAIL tout_reads: got poll=%0d reads=%0d want 4 4", poll_cnt, rd_n); end
    tests++; if (cyc != 1 + 3*2 + 4*2 + 1) begin fails++; $display("FAIL tout_latency: got %0d want 16", cyc); end
  endtask

  task automatic test_busy_reset();
    int cyc; bit seen; int n;
    bp_mode = 0; done_read = 1000; wr_err_idx = -1; rd_err_idx = -1;
    cfg_data = {32'h22, 32'h11};
    do_reset();
    @(negedge ACLK);
    start = 1'b1;
    @(negedge ACLK);
    start = 1'b0;
    cfg_data = 64'hDEAD_BEEF_CAFE_F00D;
    n = 0;
    while (rd_n < 1 && n < 50) begin @(negedge ACLK); n++; end
    start = 1'b1;
    @(negedge ACLK);
    start = 1'b0;
    n = 0;
    while (!m_axi_rready && n < 50) begin @(negedge ACLK); n++; end
    tests++; if (!m_axi_rready || busy !== 1'b1 || poll_cnt === 16'd0) begin
      fails++; $display("FAIL busy_state: got rready=%0b busy=%0b poll=%0d want 1 1 nonzero", m_axi_rready, busy, poll_cnt); end
    tests++; if (wr_n != 3 || wd_log[0] !== 32'h11 || wd_log[1] !== 32'h22) begin
      fails++; $display("FAIL busy_start: got n=%0d d0=%0h d1=%0h want 3 11 22", wr_n, wd_log[0], wd_log[1]); end
    ARESET = 1'b1;
    @(negedge ACLK);
    tests++;
    if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready, busy, done} !== 7'b0 ||
        err_code !== 2'd0 || poll_cnt !== 16'd0) begin
      fails++; $display("FAIL midreset: got hs=%05b busy=%0b done=%0b err=%0d poll=%0d want all 0",
                        {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, busy, done, err_code, poll_cnt);
    end
    ARESET = 1'b0;
    done_read = 1;
    cfg_data = {32'h22, 32'h11};
    run_seq(200, cyc, seen);
    tests++; if (!seen || err_code !== 2'd0 || poll_cnt !== 16'd1) begin
      fails++; $display("FAIL restart: got seen=%0b err=%0d poll=%0d want 1 0 1", seen, err_code, poll_cnt); end
    tests++; if (wr_n != 3 || rd_n != 1 || wd_log[2] !== 32'h1) begin
      fails++; $display("FAIL restart_txns: got w=%0d r=%0d go=%0h want 3 1 1", wr_n, rd_n, wd_log[2]); end
  endtask

  task automatic test_read_err();
    int cyc; bit seen;
    bp_mode = 0; done_read = 1000; wr_err_idx = -1; rd_err_idx = 1;
    do_reset();
    run_seq(200, cyc, seen);
    tests++; if (!seen || err_code !== 2'd2) begin fails++; $display("FAIL rd_err: got seen=%0b err=%0d want 1 2", seen, err_code); end
    tests++; if (poll_cnt !== 16'd1 || rd_n != 1) begin
      fails++; $display("FAIL rd_err_counts: got poll=%0d reads=%0d want 1 1", poll_cnt, rd_n); end
    rd_err_idx = -1;
  endtask

  initial begin
    ARESET = 1'b1; start = 1'b0; cfg_data = '0;
    test_reset();
    test_zero_wait();
    test_backpressure(1);
    test_backpressure(2);
    test_back_to_back();
    test_write_err();
    test_timeout();
    test_busy_reset();
    test_read_err();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
